// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - multiplexed hex 7-segment scanner with snapshot hold register
//
// Purpose: snapshots DIGITS packed 4-bit counter values (plus decimal points) on
// LATCH, then time-multiplexes them onto one shared segment bus. Each digit owns
// a slot of PRESCALE cycles; the first cycle of every slot is a dead cycle with
// all outputs inactive, which suppresses ghosting when DIG changes.
//
// Ports:
//   CLK     in   clock
//   nCLR    in   asynchronous active-low reset
//   LATCH   in   snapshot strobe, level-sampled each CLK
//   DIN     in   4*DIGITS digit values, digit 0 in [3:0] (least significant)
//   DP      in   DIGITS decimal points, captured with DIN
//   ENABLE  in   scan enable; when low the scan position freezes, outputs go inactive
//   SEG     out  segments {g,f,e,d,c,b,a}
//   SEG_DP  out  decimal point segment
//   DIG     out  one-hot digit select
//   FRAME   out  one-cycle pulse on the last driven cycle of the last digit
//
// Parameters: DIGITS (1..8), PRESCALE (>=2), ACTIVE_LOW (inverts SEG/SEG_DP/DIG).
// Build option: define SEG7_SCAN_LZB_EN for leading-zero blanking.

module seg7_scan #(
   parameter int DIGITS     = 4,
   parameter int PRESCALE   = 4,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic                CLK,
   input  logic                nCLR,
   input  logic                LATCH,
   input  logic [4*DIGITS-1:0] DIN,
   input  logic [DIGITS-1:0]   DP,
   input  logic                ENABLE,
   output logic [6:0]          SEG,
   output logic                SEG_DP,
   output logic [DIGITS-1:0]   DIG,
   output logic                FRAME
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [PW-1:0]     P_LAST  = PW'(PRESCALE - 1);
   localparam logic [IW-1:0]     I_LAST  = IW'(DIGITS - 1);
   localparam logic [6:0]        SEG_OFF = {7{ACTIVE_LOW}};
   localparam logic [DIGITS-1:0] DIG_OFF = {DIGITS{ACTIVE_LOW}};

   logic [4*DIGITS-1:0] hold_q, hold_d;
   logic [DIGITS-1:0]   hold_dp_q, hold_dp_d;
   logic [PW-1:0]       p_q, p_d;
   logic [IW-1:0]       i_q, i_d;
   logic [6:0]          seg_q, seg_d;
   logic                seg_dp_q, seg_dp_d;
   logic [DIGITS-1:0]   dig_q, dig_d;
   logic                frame_q, frame_d;

   logic [3:0]          cur_nib;
   logic                cur_dp;
   logic                blank;
   logic                drive;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0:    hex7 = 7'h3F;
         4'h1:    hex7 = 7'h06;
         4'h2:    hex7 = 7'h5B;
         4'h3:    hex7 = 7'h4F;
         4'h4:    hex7 = 7'h66;
         4'h5:    hex7 = 7'h6D;
         4'h6:    hex7 = 7'h7D;
         4'h7:    hex7 = 7'h07;
         4'h8:    hex7 = 7'h7F;
         4'h9:    hex7 = 7'h6F;
         4'hA:    hex7 = 7'h77;
         4'hB:    hex7 = 7'h7C;
         4'hC:    hex7 = 7'h39;
         4'hD:    hex7 = 7'h5E;
         4'hE:    hex7 = 7'h79;
         default: hex7 = 7'h71;
      endcase
   endfunction

   // Mux the currently scanned digit out of the hold register.
   always_comb begin
      cur_nib = 4'h0;
      cur_dp  = 1'b0;
      for (int k = 0; k < DIGITS; k++) begin
         if (i_q == IW'(k)) begin
            cur_nib = hold_q[4*k +: 4];
            cur_dp  = hold_dp_q[k];
         end
      end
   end

`ifdef SEG7_SCAN_LZB_EN
   // zero_up[k] is set when digit k and every more significant digit are zero.
   logic [DIGITS-1:0] zero_up;
   logic              zero_sel;

   always_comb begin
      logic all_zero;
      all_zero = 1'b1;
      zero_up  = '0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         all_zero   = all_zero & (hold_q[4*k +: 4] == 4'h0);
         zero_up[k] = all_zero;
      end
   end

   always_comb begin
      zero_sel = 1'b0;
      for (int k = 0; k < DIGITS; k++) begin
         if (i_q == IW'(k)) zero_sel = zero_up[k];
      end
   end

   // Digit 0 always shows, so a value of zero still displays "0".
   assign blank = (i_q != '0) && zero_sel;
`else
   assign blank = 1'b0;
`endif

   always_comb begin
      hold_d    = hold_q;
      hold_dp_d = hold_dp_q;
      if (LATCH) begin
         hold_d    = DIN;
         hold_dp_d = DP;
      end

      p_d = p_q;
      i_d = i_q;
      if (ENABLE) begin
         if (p_q == P_LAST) begin
            p_d = '0;
            i_d = (i_q == I_LAST) ? '0 : i_q + 1'b1;
         end else begin
            p_d = p_q + 1'b1;
         end
      end

      // p==0 is the dead cycle at the start of each slot.
      drive    = ENABLE && (p_q != '0);
      seg_d    = SEG_OFF;
      seg_dp_d = ACTIVE_LOW;
      dig_d    = DIG_OFF;
      if (drive) begin
         seg_d    = (blank ? 7'h00 : hex7(cur_nib)) ^ SEG_OFF;
         seg_dp_d = cur_dp ^ ACTIVE_LOW;
         dig_d    = (DIGITS'(1) << i_q) ^ DIG_OFF;
      end

      frame_d = ENABLE && (p_q == P_LAST) && (i_q == I_LAST);
   end

   always_ff @(posedge CLK or negedge nCLR) begin
      if (!nCLR) begin
         hold_q    <= '0;
         hold_dp_q <= '0;
         p_q       <= '0;
         i_q       <= '0;
         seg_q     <= SEG_OFF;
         seg_dp_q  <= ACTIVE_LOW;
         dig_q     <= DIG_OFF;
         frame_q   <= 1'b0;
      end else begin
         hold_q    <= hold_d;
         hold_dp_q <= hold_dp_d;
         p_q       <= p_d;
         i_q       <= i_d;
         seg_q     <= seg_d;
         seg_dp_q  <= seg_dp_d;
         dig_q     <= dig_d;
         frame_q   <= frame_d;
      end
   end

   assign SEG    = seg_q;
   assign SEG_DP = seg_dp_q;
   assign DIG    = dig_q;
   assign FRAME  = frame_q;

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Multiplexed 7-segment display driver sitting directly downstream of a chain of cascaded 4-bit binary counters. It snapshots the counters' parallel outputs on a strobe and decodes each 4-bit digit to hex 7-segment patterns. It time-multiplexes the digits onto one shared segment bus with a one-hot digit select, and inserts a dead cycle at each digit change to suppress ghosting.

## Interface
- DIGITS, 4: number of digits, legal 1..8.
- PRESCALE, 4: CLK cycles per digit slot, legal ≥ 2.
- ACTIVE_LOW, 0: when 1, SEG, SEG_DP and DIG are inverted at the output registers.

- CLK  in  1  clock.
- nCLR  in  1  reset; asynchronous, active-low.
- LATCH  in  1  snapshot strobe; level-sampled each CLK.
- DIN  in  4*DIGITS  digit values; digit 0 is bits [3:0] and is least significant.
- DP  in  DIGITS  decimal point per digit, captured with DIN.
- ENABLE  in  1  scan enable.
- SEG  out  7  segments {g,f,e,d,c,b,a}, bit 0 = a.
- SEG_DP  out  1  decimal point segment.
- DIG  out  DIGITS  one-hot digit select.
- FRAME  out  1  one-cycle pulse at end of full scan.

## Operation
- Snapshot: on each CLK edge with LATCH=1, the hold register loads DIN and DP. The new value is visible on SEG one cycle later.
- State: prescaler `p` counts 0..PRESCALE-1, width clog2(PRESCALE). Digit index `i` counts 0..DIGITS-1, width max(1, clog2(DIGITS)).
- Counting, ENABLE=1: p increments each edge. When p==PRESCALE-1, p wraps to 0 and i increments, wrapping DIGITS-1 → 0.
- ENABLE=0: p and i hold their values. On the next edge the outputs go inactive. Scanning resumes from the held p/i when ENABLE returns to 1.
- Output registers update every edge from the pre-edge state:
  - DIG = onehot(i) if ENABLE and p≠0, else 0. The p=0 cycle is the dead cycle.
  - SEG = decode(hold[i]) and SEG_DP = hold_dp[i] under the same condition, else all inactive.
  - FRAME = 1 iff ENABLE and p==PRESCALE-1 and i==DIGITS-1.
- Hex decode, active-high form: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- ACTIVE_LOW=1 inverts all three output buses, including their inactive state. FRAME is never inverted.

## Timing
- Reset, asynchronous and effective without a clock edge:
  - hold and hold_dp = 0; p = 0; i = 0.
  - SEG, SEG_DP and DIG inactive: 0 when ACTIVE_LOW=0, all ones when ACTIVE_LOW=1.
  - FRAME = 0.
- Reset release with ENABLE=1:
  - Edge 1: dead cycle, DIG stays inactive.
  - Edge 2: DIG=onehot(0).
- Output latency is one CLK from state to pins. SEG and DIG always change on the same edge.
- Slot structure: each digit is driven for PRESCALE-1 cycles plus 1 dead cycle. A full frame is DIGITS*PRESCALE cycles. FRAME asserts once per frame.
- LATCH during active scan: the current slot switches to the new value one edge later. No tearing within a single digit.
- nCLR asserted mid-slot: outputs go inactive immediately. The scan restarts at digit 0 with a dead cycle.

## Configuration
- SEG7_SCAN_LZB_EN defined (leading-zero blanking):
  - A digit k>0 is blanked if hold[k] and every higher digit are all 0. Blanked means SEG inactive.
  - DIG and SEG_DP are still driven normally for a blanked digit.
  - Digit 0 is never blanked.
- SEG7_SCAN_LZB_EN undefined: every digit is decoded.

## Test plan
- Reset: DIGITS=4, ACTIVE_LOW=0, mid-scan assert nCLR between edges → SEG=00, DIG=0000, FRAME=0 immediately.
- Scan: LATCH one cycle with DIN=16'h1234, ENABLE=1, PRESCALE=4 → per slot 1 dead cycle then 3 cycles of the digit:
  - SEG=66 with DIG=0001, then SEG=4F with DIG=0010, then 5B/0100, then 06/1000, then repeat.
- Frame: free-run 64 cycles → exactly 4 FRAME pulses, 16 cycles apart, each coincident with the last edge of the digit-3 slot.
- Freeze: drop ENABLE mid digit-2 slot for 5 cycles → outputs inactive from the next edge. After re-enable, digit 2 completes its remaining cycles.
- Blanking: DIN=16'h0070.
  - With SEG7_SCAN_LZB_EN: digits 3 and 2 give SEG=00 with DIG still asserted; digit 1 = 07; digit 0 = 3F.
  - Without the macro: digits 3 and 2 give 3F.
- Polarity: ACTIVE_LOW=1 → during reset SEG=7F, SEG_DP=1, DIG=1111. Digit 0 active showing 8 → SEG=00, DIG=1110.
